// File: rtl/threshold_scan.sv
`default_nettype none
// ============================================================================
// Module   : threshold_scan
// Purpose  : Streaming histogram threshold finder. Takes histogram chunks from
//            the brightest bin downward, accumulates counts and reports the
//            first bin at which the cumulative count reaches the target.
// Options  : THRESHOLD_ORDER_CHECK_EN - adds chunk-order checking and the
//            o_order_err output.
// Revision : 1.0 - initial release
// ============================================================================
module threshold_scan #(
    parameter int BIN_W          = 16,
    parameter int BINS_PER_CHUNK = 8,
    parameter int NUM_BINS       = 256,
    parameter int IDX_W          = 8,
    parameter int ACC_W          = 24
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [ACC_W-1:0]                i_target_count,
    input  logic                            i_chunk_valid,
    output logic                            o_chunk_ready,
    input  logic [BINS_PER_CHUNK*BIN_W-1:0] i_histogram_chunk,
    input  logic [IDX_W-1:0]                i_bin_index,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_found,
    output logic [IDX_W-1:0]                o_threshold,
    output logic [ACC_W-1:0]                o_cum_count
`ifdef THRESHOLD_ORDER_CHECK_EN
    ,
    output logic                            o_order_err
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] c_FIRST_BASE = IDX_W'(NUM_BINS - BINS_PER_CHUNK);
    localparam logic [IDX_W-1:0] c_STEP       = IDX_W'(BINS_PER_CHUNK);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_target;
    logic [IDX_W-1:0] r_thr;

    logic             w_xfer;
    logic             w_last;
    logic             w_bad;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_k;
    logic [IDX_W-1:0] w_hit_idx;
    logic [ACC_W-1:0] w_cum_all;

    // Accumulate one bin count, clamping at the all-ones maximum.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [BIN_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-BIN_W){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign o_chunk_ready = (r_state == c_ST_SCAN) || (r_state == c_ST_DRAIN);
    assign o_busy        = o_chunk_ready;
    assign w_xfer        = i_chunk_valid & o_chunk_ready;
    assign w_last        = (i_bin_index == '0);
    assign w_hit_idx     = i_bin_index + w_hit_k;

    // Walk the chunk from its brightest bin down, finding the first crossing.
    always_comb begin
        logic [ACC_W-1:0] cum;
        cum     = r_acc;
        w_hit   = 1'b0;
        w_hit_k = '0;
        for (int k = BINS_PER_CHUNK - 1; k >= 0; k--) begin
            cum = sat_add(cum, i_histogram_chunk[k*BIN_W +: BIN_W]);
            if (!w_hit && (cum >= r_target)) begin
                w_hit   = 1'b1;
                w_hit_k = IDX_W'(k);
            end
        end
        w_cum_all = cum;
    end

`ifdef THRESHOLD_ORDER_CHECK_EN
    logic [IDX_W-1:0] r_exp_base;

    assign w_bad = (i_bin_index != r_exp_base);

    // Track the base the next chunk must carry and flag out-of-order chunks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_base  <= c_FIRST_BASE;
            o_order_err <= 1'b0;
        end else begin
            o_order_err <= 1'b0;
            if ((r_state == c_ST_IDLE) && i_start) begin
                r_exp_base <= c_FIRST_BASE;
            end else if (w_xfer) begin
                if (w_bad) begin
                    o_order_err <= 1'b1;
                end else begin
                    r_exp_base <= r_exp_base - c_STEP;
                end
            end
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    // Scan control, accumulator and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_acc       <= '0;
            r_target    <= '0;
            r_thr       <= '0;
            o_done      <= 1'b0;
            o_found     <= 1'b0;
            o_threshold <= '0;
            o_cum_count <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= c_ST_SCAN;
                        r_target <= i_target_count;
                        r_acc    <= '0;
                        r_thr    <= '0;
                        o_found  <= 1'b0;
                    end
                end
                c_ST_SCAN: begin
                    if (w_xfer) begin
                        if (w_bad) begin
                            // Bad chunk is dropped; report what was summed so far.
                            r_state     <= c_ST_DONE;
                            o_done      <= 1'b1;
                            o_found     <= 1'b0;
                            o_threshold <= '0;
                            o_cum_count <= r_acc;
                        end else begin
                            r_acc <= w_cum_all;
                            if (w_hit) begin
                                r_thr <= w_hit_idx;
                            end
                            if (w_last) begin
                                r_state     <= c_ST_DONE;
                                o_done      <= 1'b1;
                                o_found     <= w_hit;
                                o_threshold <= w_hit ? w_hit_idx : '0;
                                o_cum_count <= w_cum_all;
                            end else if (w_hit) begin
                                r_state <= c_ST_DRAIN;
                            end
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // Remaining chunks are consumed without touching acc/threshold.
                    if (w_xfer && (w_bad || w_last)) begin
                        r_state     <= c_ST_DONE;
                        o_done      <= 1'b1;
                        o_found     <= !w_bad;
                        o_threshold <= w_bad ? '0 : r_thr;
                        o_cum_count <= r_acc;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_threshold_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_scan
// Purpose  : Self-checking bench for threshold_scan with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_scan;

    localparam int BIN_W  = 16;
    localparam int BPC    = 8;
    localparam int NBINS  = 256;
    localparam int IDX_W  = 8;
    localparam int ACC_W  = 24;
    localparam int NCHUNK = NBINS / BPC;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [ACC_W-1:0]       target;
    logic                   cvalid;
    logic                   cready;
    logic [BPC*BIN_W-1:0]   chunk;
    logic [IDX_W-1:0]       bidx;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [IDX_W-1:0]       thr;
    logic [ACC_W-1:0]       cum;
`ifdef THRESHOLD_ORDER_CHECK_EN
    logic                   order_err;
`endif

    threshold_scan #(
        .BIN_W(BIN_W), .BINS_PER_CHUNK(BPC), .NUM_BINS(NBINS), .IDX_W(IDX_W), .ACC_W(ACC_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_target_count(target),
        .i_chunk_valid(cvalid), .o_chunk_ready(cready), .i_histogram_chunk(chunk),
        .i_bin_index(bidx), .o_busy(busy), .o_done(done), .o_found(found),
        .o_threshold(thr), .o_cum_count(cum)
`ifdef THRESHOLD_ORDER_CHECK_EN
        , .o_order_err(order_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] thr;
        logic [ACC_W-1:0] cum;
    } exp_t;

    exp_t           sb[$];
    logic [BIN_W-1:0] hist [NBINS];
    int             checks = 0;
    int             errors = 0;

    // Observations captured by the driver
    int             n_xfers;
    logic           done_first;
    logic           done_once;
    logic           got_found;
    logic [IDX_W-1:0] got_thr;
    logic [ACC_W-1:0] got_cum;
    logic           got_err;
    logic           mid_busy;

    // Reference: running saturating sum over bins, brightest first.
    function automatic exp_t model(input logic [ACC_W-1:0] tgt);
        exp_t        e;
        logic [ACC_W:0] s;
        logic [ACC_W-1:0] run;
        logic        frozen;
        e = '0; run = '0; frozen = 1'b0;
        for (int i = NBINS - 1; i >= 0; i--) begin
            s   = {1'b0, run} + {{(ACC_W+1-BIN_W){1'b0}}, hist[i]};
            run = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
            if (!e.found && run >= tgt) begin
                e.found = 1'b1;
                e.thr   = IDX_W'(i);
            end
            if ((i % BPC) == 0 && e.found && !frozen) begin
                e.cum  = run;
                frozen = 1'b1;
            end
        end
        if (!e.found) e.cum = run;
        return e;
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < NBINS; i++) hist[i] = '0;
    endtask

    // Start a scan and feed chunks; entered and left at posedge+1.
    task automatic drive_scan(input logic [ACC_W-1:0] tgt, input int gap_pct,
                              input int start_at, input int nch, input int skip_at);
        int base;
        int waits;
        n_xfers  = 0;
        mid_busy = 1'b1;
        target = tgt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < nch; c++) begin
            base = NBINS - BPC - BPC * (c + ((c >= skip_at) ? 1 : 0));
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                cvalid = 1'b0;
                @(posedge clk); #1;
            end
            for (int k = 0; k < BPC; k++) chunk[k*BIN_W +: BIN_W] = hist[base + k];
            bidx   = IDX_W'(base);
            cvalid = 1'b1;
            if (c == start_at) begin
                start  = 1'b1;
                target = '0;
            end
            waits = 0;
            forever begin
                @(posedge clk);
                if (cready) break;
                waits++;
                if (waits > 20) break;
            end
            #1;
            start = 1'b0;
            if (waits > 20) begin
                errors++;
                $display("FAIL handshake_timeout chunk %0d: ready stayed %0b, required 1", c, cready);
            end else begin
                n_xfers++;
            end
            if (c < nch - 1 && !busy) mid_busy = 1'b0;
        end
        cvalid = 1'b0;
        @(negedge clk);
        done_first = done;
        got_found  = found;
        got_thr    = thr;
        got_cum    = cum;
`ifdef THRESHOLD_ORDER_CHECK_EN
        got_err    = order_err;
`else
        got_err    = 1'b0;
`endif
        @(negedge clk);
        done_once = !done;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cvalid = 1'b0; target = '0; chunk = '0; bidx = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, cready, done, found} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b, required 0000", {busy, cready, done, found}); end
        checks++; if (thr !== '0) begin errors++; $display("FAIL reset_thr: got %0d, required 0", thr); end
        checks++; if (cum !== '0) begin errors++; $display("FAIL reset_cum: got %0d, required 0", cum); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Shared result comparison written out per scenario below.
    task automatic test_single_bin();
        exp_t e;
        clear_hist(); hist[200] = 16'd12;
        sb.push_back(model(24'd10));
        drive_scan(24'd10, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if (got_found !== e.found) begin errors++; $display("FAIL single_found: got %0b, required %0b", got_found, e.found); end
        checks++; if (got_thr !== e.thr) begin errors++; $display("FAIL single_thr: got %0d, required %0d", got_thr, e.thr); end
        checks++; if (got_cum !== e.cum) begin errors++; $display("FAIL single_cum: got %0d, required %0d", got_cum, e.cum); end
        checks++; if (n_xfers !== NCHUNK) begin errors++; $display("FAIL single_xfers: got %0d, required %0d", n_xfers, NCHUNK); end
        checks++; if (done_first !== 1'b1) begin errors++; $display("FAIL single_done_latency: got %0b, required 1", done_first); end
        checks++; if (done_once !== 1'b1) begin errors++; $display("FAIL single_done_width: done still high"); end
        checks++; if (found !== 1'b1 || thr !== 8'd200) begin errors++; $display("FAIL single_hold: found %0b thr %0d, required 1 200", found, thr); end
    endtask

    task automatic test_all_zero();
        exp_t e;
        clear_hist();
        sb.push_back(model(24'd100));
        drive_scan(24'd100, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if ({got_found, got_thr, got_cum} !== {e.found, e.thr, e.cum}) begin errors++; $display("FAIL zero_result: got %0b/%0d/%0d, required %0b/%0d/%0d", got_found, got_thr, got_cum, e.found, e.thr, e.cum); end
        checks++; if (n_xfers !== NCHUNK || done_first !== 1'b1) begin errors++; $display("FAIL zero_done: xfers %0d done %0b, required %0d 1", n_xfers, done_first, NCHUNK); end
    endtask

    task automatic test_target_zero();
        exp_t e;
        for (int i = 0; i < NBINS; i++) hist[i] = BIN_W'($urandom_range(0, 1000));
        sb.push_back(model(24'd0));
        drive_scan(24'd0, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if (got_found !== 1'b1 || got_thr !== e.thr) begin errors++; $display("FAIL tz_thr: got %0b/%0d, required 1/%0d", got_found, got_thr, e.thr); end
        checks++; if (got_cum !== e.cum) begin errors++; $display("FAIL tz_cum: got %0d, required %0d", got_cum, e.cum); end
        checks++; if (mid_busy !== 1'b1 || n_xfers !== NCHUNK || done_first !== 1'b1) begin errors++; $display("FAIL tz_drain: busy %0b xfers %0d done %0b, required 1 %0d 1", mid_busy, n_xfers, done_first, NCHUNK); end
    endtask

    task automatic test_equality();
        exp_t e;
        clear_hist(); hist[255] = 16'd5; hist[254] = 16'd5;
        sb.push_back(model(24'd10));
        drive_scan(24'd10, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if (got_thr !== e.thr || got_found !== e.found || got_cum !== e.cum) begin errors++; $display("FAIL eq_result: got %0b/%0d/%0d, required %0b/%0d/%0d", got_found, got_thr, got_cum, e.found, e.thr, e.cum); end
    endtask

    task automatic test_boundary();
        exp_t e;
        clear_hist(); hist[248] = 16'd6; hist[247] = 16'd4;
        sb.push_back(model(24'd10));
        drive_scan(24'd10, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if (got_thr !== e.thr || got_found !== e.found || got_cum !== e.cum) begin errors++; $display("FAIL bnd_result: got %0b/%0d/%0d, required %0b/%0d/%0d", got_found, got_thr, got_cum, e.found, e.thr, e.cum); end
    endtask

    task automatic test_gaps_start();
        exp_t e;
        for (int i = 0; i < NBINS; i++) hist[i] = BIN_W'($urandom_range(0, 1000));
        sb.push_back(model(24'd40000));
        drive_scan(24'd40000, 0, -1, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if ({got_found, got_thr, got_cum} !== {e.found, e.thr, e.cum}) begin errors++; $display("FAIL rnd_result: got %0b/%0d/%0d, required %0b/%0d/%0d", got_found, got_thr, got_cum, e.found, e.thr, e.cum); end
        sb.push_back(model(24'd40000));
        drive_scan(24'd40000, 40, 10, NCHUNK, 99);
        e = sb.pop_front();
        checks++; if ({got_found, got_thr, got_cum} !== {e.found, e.thr, e.cum}) begin errors++; $display("FAIL gap_result: got %0b/%0d/%0d, required %0b/%0d/%0d", got_found, got_thr, got_cum, e.found, e.thr, e.cum); end
        checks++; if (n_xfers !== NCHUNK || done_first !== 1'b1 || done_once !== 1'b1) begin errors++; $display("FAIL gap_done: xfers %0d done %0b once %0b, required %0d 1 1", n_xfers, done_first, done_once, NCHUNK); end
    endtask

    task automatic test_async_reset();
        logic saw_done;
        // Previous scan left o_found/o_threshold set; reset must clear them.
        target = 24'd40000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cvalid = 1'b1; bidx = 8'd248; chunk = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, cready, done, found} !== 4'b0) begin errors++; $display("FAIL arst_flags: got %b, required 0000", {busy, cready, done, found}); end
        checks++; if (thr !== '0 || cum !== '0) begin errors++; $display("FAIL arst_result: thr %0d cum %0d, required 0 0", thr, cum); end
        cvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL arst_idle: done/busy seen %0b, required 0", saw_done); end
        @(posedge clk); #1;
    endtask

`ifdef THRESHOLD_ORDER_CHECK_EN
    task automatic test_order_err();
        logic [ACC_W-1:0] exp_cum;
        for (int i = 0; i < NBINS; i++) hist[i] = BIN_W'($urandom_range(1, 100));
        exp_cum = '0;
        for (int i = 248; i < 256; i++) exp_cum = exp_cum + ACC_W'(hist[i]);
        drive_scan(24'hFFFFFF, 0, -1, 2, 1);
        checks++; if (got_err !== 1'b1 || done_first !== 1'b1) begin errors++; $display("FAIL order_err: err %0b done %0b, required 1 1", got_err, done_first); end
        checks++; if (got_found !== 1'b0 || got_thr !== '0) begin errors++; $display("FAIL order_result: found %0b thr %0d, required 0 0", got_found, got_thr); end
        checks++; if (got_cum !== exp_cum) begin errors++; $display("FAIL order_cum: got %0d, required %0d", got_cum, exp_cum); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_bin();
        test_all_zero();
        test_target_zero();
        test_equality();
        test_boundary();
        test_gaps_start();
        test_async_reset();
`ifdef THRESHOLD_ORDER_CHECK_EN
        test_order_err();
`endif
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
